// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the data cache and main memory: queues evicted dirty
// lines in a circular FIFO, coalesces repeat evictions, serves read-miss lookups and drains on request.
module dcache_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 128,
  parameter int LIDX_W = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     evict_valid,
  output logic                     evict_ready,
  input  logic [LIDX_W-1:0]        evict_addr,
  input  logic [LINE_W-1:0]        evict_data,
  input  logic [LIDX_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [LINE_W-1:0]        lookup_data,
  output logic                     mem_req,
  output logic [LIDX_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_data,
  input  logic                     mem_ack,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t             state_q, state_d;
  logic [LIDX_W-1:0]  addr_q [DEPTH];
  logic [LINE_W-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drain_pending_q;

  logic               in_flight;
  logic               coalesce_match;
  logic [PTR_W-1:0]   coalesce_idx;
  logic               evict_fire;
  logic               alloc;
  logic               coalesce_wr;
  logic               pop;
  logic               head_hit;

  assign in_flight = (state_q == S_WRITE);

  // The in-flight head is excluded so a rewrite of a line already being sent
  // gets its own entry instead of mutating data memory may be mid-way through taking.
  // NOTE: every always_comb output gets a default first, otherwise a missed path infers a latch.
  always_comb begin
    coalesce_match = 1'b0;
    coalesce_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == evict_addr) &&
          !(in_flight && (PTR_W'(i) == head_q))) begin
        coalesce_match = 1'b1;
        coalesce_idx   = PTR_W'(i);
      end
    end
  end

  assign evict_ready = reset && !drain_pending_q && ((count_q < FULL) || coalesce_match);
  assign evict_fire  = evict_valid && evict_ready;
  assign alloc       = evict_fire && !coalesce_match;
  assign coalesce_wr = evict_fire && coalesce_match;
  assign pop         = in_flight && mem_ack;
  assign count_d     = count_q + CNT_W'(alloc) - CNT_W'(pop);

  // A non-head match is always younger than the head, so it wins when both hit.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    head_hit    = valid_q[head_q] && (addr_q[head_q] == lookup_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == lookup_addr) && (PTR_W'(i) != head_q)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[i];
      end
    end
    if (!lookup_hit && head_hit) begin
      lookup_hit  = 1'b1;
      lookup_data = data_q[head_q];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_WRITE;
      S_WRITE: if (pop && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req    = in_flight;
  assign mem_addr   = in_flight ? addr_q[head_q] : '0;
  assign mem_data   = in_flight ? data_q[head_q] : '0;
  assign drain_done = reset && drain_pending_q && (count_q == '0) && (state_q == S_IDLE);
  assign count      = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      valid_q         <= '0;
      drain_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (drain_done) begin
        drain_pending_q <= 1'b0;
      end else if (drain_req) begin
        drain_pending_q <= 1'b1;
      end
    end
  end

  // NOTE: the line storage is not reset; every reader is qualified by valid_q
  // or by the WRITE state, so stale contents are never observable.
  always_ff @(posedge clock) begin
    if (alloc) begin
      addr_q[tail_q] <= evict_addr;
      data_q[tail_q] <= evict_data;
    end else if (coalesce_wr) begin
      data_q[coalesce_idx] <= evict_data;
    end
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer: a per-cycle vector table plus hand-written
// sequences for FIFO ordering/wrap, drain and reset during a drain.
module tb_dcache_wb_buffer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         evict_valid = 1'b0;
  logic         evict_ready;
  logic [9:0]   evict_addr = '0;
  logic [127:0] evict_data = '0;
  logic [9:0]   lookup_addr = '0;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic         mem_req;
  logic [9:0]   mem_addr;
  logic [127:0] mem_data;
  logic         mem_ack = 1'b0;
  logic         drain_req = 1'b0;
  logic         drain_done;
  logic [2:0]   count;

  dcache_wb_buffer #(.DEPTH(4), .LINE_W(128), .LIDX_W(10)) dut (
    .clock(clock), .reset(reset),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_data(evict_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .drain_req(drain_req), .drain_done(drain_done), .count(count)
  );

  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic         rst;
    logic         ev_valid;
    logic [9:0]   ev_addr;
    logic [127:0] ev_data;
    logic [9:0]   lk_addr;
    logic         ack;
    logic         drn;
    logic         e_ready;
    logic         e_hit;
    logic [127:0] e_ldata;
    logic         e_req;
    logic [9:0]   e_maddr;
    logic [127:0] e_mdata;
    logic         e_done;
    logic [2:0]   e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] dat(input logic [7:0] tag);
    return {16{tag}};
  endfunction

  function automatic vec_t v(input logic rst, input logic evv, input logic [9:0] ea,
                             input logic [7:0] et, input logic [9:0] lk, input logic ack,
                             input logic drn, input logic er, input logic eh,
                             input logic [7:0] elt, input logic erq, input logic [9:0] ema,
                             input logic [7:0] emt, input logic ed, input logic [2:0] ec);
    vec_t r;
    r.rst = rst;   r.ev_valid = evv; r.ev_addr = ea; r.ev_data = dat(et);
    r.lk_addr = lk; r.ack = ack;     r.drn = drn;
    r.e_ready = er; r.e_hit = eh;    r.e_ldata = dat(elt);
    r.e_req = erq;  r.e_maddr = ema; r.e_mdata = dat(emt);
    r.e_done = ed;  r.e_count = ec;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    lookup_addr = '0; mem_ack = 1'b0; drain_req = 1'b0;
  endtask

  logic [9:0]   got_addr[$];
  logic [127:0] got_data[$];

  initial begin
    // One reset edge so the table starts from a known state.
    reset = 1'b0;
    tick();

    //                 rst evv ea      et     lk      ack drn  er eh elt    rq ma      mt     d  cnt
    vecs.push_back(v(0, 0, 10'h000, 8'h00, 10'h000, 0, 0,   0, 0, 8'h00, 0, 10'h000, 8'h00, 0, 0));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h003, 1, 0,   1, 0, 8'h00, 0, 10'h000, 8'h00, 0, 0));
    vecs.push_back(v(1, 1, 10'h003, 8'h0F, 10'h003, 0, 0,   1, 0, 8'h00, 0, 10'h000, 8'h00, 0, 0));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h003, 0, 0,   1, 1, 8'h0F, 0, 10'h000, 8'h00, 0, 1));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h003, 1, 0,   1, 1, 8'h0F, 1, 10'h003, 8'h0F, 0, 1));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h003, 1, 0,   1, 0, 8'h00, 0, 10'h000, 8'h00, 0, 0));
    vecs.push_back(v(1, 1, 10'h010, 8'hA0, 10'h011, 0, 0,   1, 0, 8'h00, 0, 10'h000, 8'h00, 0, 0));
    vecs.push_back(v(1, 1, 10'h011, 8'hA1, 10'h011, 0, 0,   1, 0, 8'h00, 0, 10'h000, 8'h00, 0, 1));
    vecs.push_back(v(1, 1, 10'h012, 8'hA2, 10'h011, 0, 0,   1, 1, 8'hA1, 1, 10'h010, 8'hA0, 0, 2));
    vecs.push_back(v(1, 1, 10'h013, 8'hA3, 10'h011, 0, 0,   1, 1, 8'hA1, 1, 10'h010, 8'hA0, 0, 3));
    vecs.push_back(v(1, 1, 10'h014, 8'hB4, 10'h011, 0, 0,   0, 1, 8'hA1, 1, 10'h010, 8'hA0, 0, 4));
    vecs.push_back(v(1, 1, 10'h011, 8'hC1, 10'h011, 0, 0,   1, 1, 8'hA1, 1, 10'h010, 8'hA0, 0, 4));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h011, 0, 0,   0, 1, 8'hC1, 1, 10'h010, 8'hA0, 0, 4));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h010, 1, 0,   0, 1, 8'hA0, 1, 10'h010, 8'hA0, 0, 4));
    vecs.push_back(v(1, 1, 10'h011, 8'hE1, 10'h011, 0, 0,   1, 1, 8'hC1, 1, 10'h011, 8'hC1, 0, 3));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h011, 1, 0,   0, 1, 8'hE1, 1, 10'h011, 8'hC1, 0, 4));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h011, 1, 0,   1, 1, 8'hE1, 1, 10'h012, 8'hA2, 0, 3));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h011, 1, 0,   1, 1, 8'hE1, 1, 10'h013, 8'hA3, 0, 2));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h011, 1, 0,   1, 1, 8'hE1, 1, 10'h011, 8'hE1, 0, 1));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h011, 0, 0,   1, 0, 8'h00, 0, 10'h000, 8'h00, 0, 0));
    vecs.push_back(v(1, 1, 10'h010, 8'hF0, 10'h010, 0, 0,   1, 0, 8'h00, 0, 10'h000, 8'h00, 0, 0));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h010, 1, 0,   1, 1, 8'hF0, 0, 10'h000, 8'h00, 0, 1));
    vecs.push_back(v(1, 1, 10'h010, 8'hF1, 10'h010, 0, 0,   1, 1, 8'hF0, 1, 10'h010, 8'hF0, 0, 1));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h010, 1, 0,   1, 1, 8'hF1, 1, 10'h010, 8'hF0, 0, 2));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h010, 1, 0,   1, 1, 8'hF1, 1, 10'h010, 8'hF1, 0, 1));
    vecs.push_back(v(1, 0, 10'h000, 8'h00, 10'h010, 0, 0,   1, 0, 8'h00, 0, 10'h000, 8'h00, 0, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst;         evict_valid = vecs[i].ev_valid;
      evict_addr = vecs[i].ev_addr; evict_data = vecs[i].ev_data;
      lookup_addr = vecs[i].lk_addr; mem_ack = vecs[i].ack; drain_req = vecs[i].drn;
      @(negedge clock);
      check($sformatf("row%0d_ready", i), evict_ready, vecs[i].e_ready);
      check($sformatf("row%0d_hit", i),   lookup_hit,  vecs[i].e_hit);
      check($sformatf("row%0d_ldata", i), lookup_data, vecs[i].e_ldata);
      check($sformatf("row%0d_req", i),   mem_req,     vecs[i].e_req);
      check($sformatf("row%0d_maddr", i), mem_addr,    vecs[i].e_maddr);
      check($sformatf("row%0d_mdata", i), mem_data,    vecs[i].e_mdata);
      check($sformatf("row%0d_done", i),  drain_done,  vecs[i].e_done);
      check($sformatf("row%0d_count", i), count,       vecs[i].e_count);
      tick();
    end

    // Ordering and wrap: 10 distinct lines, mem_ack toggling every cycle.
    begin
      int sent = 0;
      int cyc  = 0;
      idle_inputs();
      while ((sent < 10 || count != 0) && cyc < 300) begin
        evict_valid = (sent < 10);
        evict_addr  = 10'h100 + 10'(sent);
        evict_data  = dat(8'h30 + 8'(sent));
        mem_ack     = cyc[0];
        @(negedge clock);
        if (mem_req && mem_ack) begin
          got_addr.push_back(mem_addr);
          got_data.push_back(mem_data);
        end
        if (evict_valid && evict_ready) sent++;
        tick();
        cyc++;
      end
      idle_inputs();
      check("wrap_in_time", (cyc < 300) ? 1'b1 : 1'b0, 1'b1);
      check("wrap_n_writes", got_addr.size(), 10);
      for (int k = 0; k < 10 && k < got_addr.size(); k++) begin
        check($sformatf("wrap_addr%0d", k), got_addr[k], 10'h100 + 10'(k));
        check($sformatf("wrap_data%0d", k), got_data[k], dat(8'h30 + 8'(k)));
      end
    end

    // Drain with an empty buffer: drain_done in the next cycle.
    idle_inputs();
    drain_req = 1'b1;
    @(negedge clock);
    check("edrain_done_n", drain_done, 1'b0);
    tick();
    drain_req = 1'b0;
    @(negedge clock);
    check("edrain_done_n1", drain_done, 1'b1);
    check("edrain_ready_n1", evict_ready, 1'b0);
    tick();
    @(negedge clock);
    check("edrain_done_n2", drain_done, 1'b0);
    check("edrain_ready_n2", evict_ready, 1'b1);
    tick();

    // Drain with three queued lines, each acked after five cycles.
    begin
      int ready_seen = 0;
      int done_seen  = 0;
      for (int k = 0; k < 3; k++) begin
        evict_valid = 1'b1;
        evict_addr  = 10'h200 + 10'(k);
        evict_data  = dat(8'h20 + 8'(k));
        tick();
      end
      evict_valid = 1'b0;
      drain_req   = 1'b1;
      tick();
      drain_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
        for (int w = 0; w < 5; w++) begin
          evict_valid = 1'b1;
          evict_addr  = 10'h2FF;
          evict_data  = dat(8'h77);
          mem_ack     = 1'b0;
          drain_req   = (k == 1 && w == 2);
          @(negedge clock);
          if (evict_ready) ready_seen++;
          if (drain_done) done_seen++;
          tick();
        end
        drain_req = 1'b0;
        mem_ack   = 1'b1;
        @(negedge clock);
        check($sformatf("drain_req%0d", k), mem_req, 1'b1);
        check($sformatf("drain_addr%0d", k), mem_addr, 10'h200 + 10'(k));
        if (evict_ready) ready_seen++;
        if (drain_done) done_seen++;
        tick();
      end
      mem_ack = 1'b0;
      @(negedge clock);
      check("drain_done_pulse", drain_done, 1'b1);
      check("drain_count0", count, 3'd0);
      check("drain_ready_still0", evict_ready, 1'b0);
      tick();
      evict_valid = 1'b0;
      @(negedge clock);
      check("drain_done_single", drain_done, 1'b0);
      check("drain_ready_back", evict_ready, 1'b1);
      tick();
      check("drain_ready_blocked", ready_seen, 0);
      check("drain_no_early_done", done_seen, 0);
    end

    // Reset while two lines are queued and a drain is pending.
    begin
      int done_seen = 0;
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
        evict_valid = 1'b1;
        evict_addr  = 10'h300 + 10'(k);
        evict_data  = dat(8'h90 + 8'(k));
        tick();
      end
      evict_valid = 1'b0;
      drain_req   = 1'b1;
      tick();
      drain_req = 1'b0;
      @(negedge clock);
      check("rdrain_count2", count, 3'd2);
      tick();
      reset = 1'b0;
      tick();
      reset       = 1'b1;
      lookup_addr = 10'h301;
      @(negedge clock);
      check("rdrain_count", count, 3'd0);
      check("rdrain_req", mem_req, 1'b0);
      check("rdrain_hit", lookup_hit, 1'b0);
      check("rdrain_ready", evict_ready, 1'b1);
      if (drain_done) done_seen++;
      tick();
      for (int w = 0; w < 6; w++) begin
        @(negedge clock);
        if (drain_done) done_seen++;
        tick();
      end
      check("rdrain_no_done", done_seen, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
